score_keeper: RTL and testbench
===============================

# score_keeper

Referee and score counter for the Pong game, clocked by the ball clock. It consumes miss events from the ball/paddle logic and keeps per-player scores. It produces the single-cycle `goal_player_*` / `win_player_*` event pulses that drive the LED animation block. It also freezes the ball while an animation plays and after a game is won.

## Interface

Parameters:
- `WIN_SCORE`, default 5: points needed to win; must be 1..2^SCORE_W-1.
- `SCORE_W`, default 4: width of the score registers.
- `HOLD_CYCLES`, default 100: ball-freeze length after a goal, in BALL_CLOCK cycles. Covers the 3-repetition goal animation (~99 cycles). Must be ≥1.
- `HOLD_W`, default 7: hold counter width; must hold HOLD_CYCLES-1.

Ports:
- `BALL_CLOCK`, input, 1: the only clock; all state updates on its rising edge.
- `RESET`, input, 1: asynchronous, active-high reset.
- `miss_left`, input, 1: ball passed player 1's (left) paddle; the point goes to player 2. Level, sampled each edge.
- `miss_right`, input, 1: ball passed player 2's (right) paddle; the point goes to player 1.
- `new_game`, input, 1: restart request; clears scores.
- `goal_player_1`, output, 1: one-cycle pulse, player 1 scored a non-winning point.
- `goal_player_2`, output, 1: one-cycle pulse, player 2 scored a non-winning point.
- `win_player_1`, output, 1: one-cycle pulse, player 1 reached WIN_SCORE.
- `win_player_2`, output, 1: one-cycle pulse, player 2 reached WIN_SCORE.
- `score_1`, output, SCORE_W: player 1 score.
- `score_2`, output, SCORE_W: player 2 score.
- `ball_freeze`, output, 1: high while the ball must be held (goal hold or game over).

## Operation

- All outputs are registered.
- Reset values:
  - state PLAY, hold counter 0
  - scores 0
  - all four pulses 0
  - `ball_freeze` 0
- **PLAY** (`ball_freeze`=0):
  - `miss_right`=1, `miss_left`=0: `score_1`+1.
    - If the new value equals WIN_SCORE: pulse `win_player_1` and go to OVER.
    - Otherwise: pulse `goal_player_1`, load the hold counter with HOLD_CYCLES-1 and go to HOLD.
  - `miss_left`=1, `miss_right`=0: same for player 2, using `score_2`, `goal_player_2` and `win_player_2`.
  - Both misses high in the same cycle: no point; stay in PLAY; no pulse.
- **HOLD** (`ball_freeze`=1):
  - Misses are ignored.
  - Counter 0: go to PLAY. Otherwise the counter decrements.
- **OVER** (`ball_freeze`=1): scores hold their final values and misses are ignored.
- **new_game**, any state:
  - Clears both scores and the hold counter and goes to PLAY; `ball_freeze` drops to 0.
  - No pulse is emitted.
  - It has priority over a miss in the same cycle; that miss is discarded.
- Pulse rules:
  - At most one of the four event pulses is high in any cycle. A goal pulse and a win pulse never coincide; the winning point emits only a win pulse.
  - Each pulse is exactly one cycle wide, even if the miss input stays high.
  - A miss held high into PLAY after a hold is counted again. The ball logic must drop its miss before the hold expires.
- Scores never exceed WIN_SCORE, so no wrap-around is possible.

## Timing

- A miss sampled at edge k sets, at the same edge k:
  - the pulse,
  - the incremented score,
  - `ball_freeze` (HOLD or OVER state).
- All three are therefore visible from edge k until edge k+1, one cycle of latency from the input being valid. The pulse clears at edge k+1.
- HOLD is entered at edge k and left at edge k+HOLD_CYCLES. `ball_freeze` is high for exactly HOLD_CYCLES cycles.
- The first miss that can be accepted is sampled at edge k+HOLD_CYCLES+1.
- `new_game` sampled at edge k: scores are 0 and `ball_freeze` is 0 from edge k.
- RESET asserted mid-HOLD or mid-pulse forces the reset values immediately, without waiting for a clock edge. The first state update happens on the first edge after RESET deasserts.

## Test plan

- **Reset:** after RESET, one cycle of `miss_right` → `score_1`=1 and `goal_player_1` high for exactly 1 cycle. `ball_freeze` high for 100 cycles, then 0.
- **Win:** WIN_SCORE=5; feed 5 `miss_left` events, each after its hold expires → 4 `goal_player_2` pulses, then `win_player_2` (no goal pulse on that cycle). `score_2`=5, `ball_freeze` stays 1. Later misses leave the scores unchanged.
- **Game over:** from OVER, `new_game` → `score_1`=`score_2`=0 and `ball_freeze`=0 on the next cycle. A following `miss_right` → `goal_player_1`.
- **Simultaneous events:** `miss_left` and `miss_right` high together in PLAY → no pulse, scores unchanged. `new_game` together with `miss_right` → scores 0, no pulse.
- **Held input:** `miss_right` held high for 150 cycles → one `goal_player_1` at cycle 1 and a second at cycle 102. `score_1` then reads 2.
- **Reset mid-hold:** RESET asserted 40 cycles into HOLD → `ball_freeze`=0 and scores 0 immediately. Normal scoring resumes after release.

Source files
------------

// File: rtl/score_keeper.sv
// Pong referee: turns miss events into per-player scores, goal/win pulses
// and a ball freeze that covers the goal animation and the game-over state.
module score_keeper #(
   parameter int unsigned WIN_SCORE   = 5,
   parameter int unsigned SCORE_W     = 4,
   parameter int unsigned HOLD_CYCLES = 100,
   parameter int unsigned HOLD_W      = 7
) (
   input  logic               BALL_CLOCK,
   input  logic               RESET,
   input  logic               miss_left,
   input  logic               miss_right,
   input  logic               new_game,
   output logic               goal_player_1,
   output logic               goal_player_2,
   output logic               win_player_1,
   output logic               win_player_2,
   output logic [SCORE_W-1:0] score_1,
   output logic [SCORE_W-1:0] score_2,
   output logic               ball_freeze
);

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      HOLD = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [SCORE_W-1:0]  score_1_inc;
   logic [SCORE_W-1:0]  score_2_inc;
   logic                point_1;
   logic                point_2;

   assign score_1_inc = score_1 + SCORE_W'(1);
   assign score_2_inc = score_2 + SCORE_W'(1);

   // A simultaneous miss on both sides is a dead ball: nobody scores.
   assign point_1 = miss_right & ~miss_left;
   assign point_2 = miss_left & ~miss_right;

   always_ff @(posedge BALL_CLOCK or posedge RESET) begin
      if (RESET) begin
         state         <= PLAY;
         hold_cnt      <= '0;
         score_1       <= '0;
         score_2       <= '0;
         goal_player_1 <= 1'b0;
         goal_player_2 <= 1'b0;
         win_player_1  <= 1'b0;
         win_player_2  <= 1'b0;
         ball_freeze   <= 1'b0;
      end else begin
         goal_player_1 <= 1'b0;
         goal_player_2 <= 1'b0;
         win_player_1  <= 1'b0;
         win_player_2  <= 1'b0;

         if (new_game) begin
            state       <= PLAY;
            hold_cnt    <= '0;
            score_1     <= '0;
            score_2     <= '0;
            ball_freeze <= 1'b0;
         end else begin
            case (state)
               PLAY: begin
                  if (point_1) begin
                     score_1     <= score_1_inc;
                     ball_freeze <= 1'b1;
                     if (score_1_inc == WIN_VAL) begin
                        win_player_1 <= 1'b1;
                        state        <= OVER;
                     end else begin
                        goal_player_1 <= 1'b1;
                        hold_cnt      <= HOLD_LOAD;
                        state         <= HOLD;
                     end
                  end else if (point_2) begin
                     score_2     <= score_2_inc;
                     ball_freeze <= 1'b1;
                     if (score_2_inc == WIN_VAL) begin
                        win_player_2 <= 1'b1;
                        state        <= OVER;
                     end else begin
                        goal_player_2 <= 1'b1;
                        hold_cnt      <= HOLD_LOAD;
                        state         <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (hold_cnt == '0) begin
                     state       <= PLAY;
                     ball_freeze <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               OVER: begin
                  ball_freeze <= 1'b1;
               end
               default: begin
                  state       <= PLAY;
                  hold_cnt    <= '0;
                  ball_freeze <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a cycle-number based reference model is
// compared every cycle, plus hand-computed literal checks of key scenarios.
module tb_score_keeper;

   localparam int unsigned WIN_SCORE   = 5;
   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned HOLD_CYCLES = 100;
   localparam int unsigned HOLD_W      = 7;

   logic               clk;
   logic               rst;
   logic               miss_left;
   logic               miss_right;
   logic               new_game;
   logic               goal_player_1;
   logic               goal_player_2;
   logic               win_player_1;
   logic               win_player_2;
   logic [SCORE_W-1:0] score_1;
   logic [SCORE_W-1:0] score_2;
   logic               ball_freeze;

   int total = 0;
   int bad   = 0;

   score_keeper #(
      .WIN_SCORE  (WIN_SCORE),
      .SCORE_W    (SCORE_W),
      .HOLD_CYCLES(HOLD_CYCLES),
      .HOLD_W     (HOLD_W)
   ) dut (
      .BALL_CLOCK   (clk),
      .RESET        (rst),
      .miss_left    (miss_left),
      .miss_right   (miss_right),
      .new_game     (new_game),
      .goal_player_1(goal_player_1),
      .goal_player_2(goal_player_2),
      .win_player_1 (win_player_1),
      .win_player_2 (win_player_2),
      .score_1      (score_1),
      .score_2      (score_2),
      .ball_freeze  (ball_freeze)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a goal at edge k freezes play up to edge k+HOLD_CYCLES;
   // only edges strictly after that may accept a new point.
   int m_s1, m_s2, m_cyc, m_frz_end;
   bit m_over, m_g1, m_g2, m_w1, m_w2, m_frz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_cyc = 0; m_frz_end = 0; m_over = 0;
         m_g1 = 0; m_g2 = 0; m_w1 = 0; m_w2 = 0; m_frz = 0;
      end else begin
         m_cyc++;
         m_g1 = 0; m_g2 = 0; m_w1 = 0; m_w2 = 0;
         if (new_game) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_frz_end = 0;
         end else if (!m_over && m_cyc > m_frz_end && (miss_left != miss_right)) begin
            if (miss_right) begin
               m_s1++;
               if (m_s1 == int'(WIN_SCORE)) begin m_w1 = 1; m_over = 1; end
               else begin m_g1 = 1; m_frz_end = m_cyc + int'(HOLD_CYCLES); end
            end else begin
               m_s2++;
               if (m_s2 == int'(WIN_SCORE)) begin m_w2 = 1; m_over = 1; end
               else begin m_g2 = 1; m_frz_end = m_cyc + int'(HOLD_CYCLES); end
            end
         end
         m_frz = m_over || (m_cyc < m_frz_end);
      end
   end

   always @(negedge clk) begin
      check("model_goal1", int'(goal_player_1), int'(m_g1));
      check("model_goal2", int'(goal_player_2), int'(m_g2));
      check("model_win1",  int'(win_player_1),  int'(m_w1));
      check("model_win2",  int'(win_player_2),  int'(m_w2));
      check("model_score1", int'(score_1), m_s1);
      check("model_score2", int'(score_2), m_s2);
      check("model_freeze", int'(ball_freeze), int'(m_frz));
   end

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int hits;
   int first_hit;
   int second_hit;

   initial begin
      rst = 1'b1; miss_left = 1'b0; miss_right = 1'b0; new_game = 1'b0;
      #12;
      check("reset_score1", int'(score_1), 0);
      check("reset_score2", int'(score_2), 0);
      check("reset_freeze", int'(ball_freeze), 0);
      check("reset_goal1",  int'(goal_player_1), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // First goal and its hold window
      miss_right = 1'b1; tick(1); miss_right = 1'b0;
      check("first_score1", int'(score_1), 1);
      check("first_goal1",  int'(goal_player_1), 1);
      check("first_freeze", int'(ball_freeze), 1);
      tick(1);
      check("first_goal1_clear", int'(goal_player_1), 0);
      tick(98);
      check("hold_last_cycle", int'(ball_freeze), 1);
      tick(1);
      check("hold_released", int'(ball_freeze), 0);

      // Player 2 runs to the win
      for (int i = 0; i < 5; i++) begin
         miss_left = 1'b1; tick(1); miss_left = 1'b0;
         check("win_seq_score2", int'(score_2), i + 1);
         check("win_seq_goal2", int'(goal_player_2), (i < 4) ? 1 : 0);
         check("win_seq_win2",  int'(win_player_2),  (i == 4) ? 1 : 0);
         if (i < 4) tick(100);
      end
      miss_right = 1'b1; tick(5); miss_right = 1'b0;
      check("over_score1", int'(score_1), 1);
      check("over_score2", int'(score_2), 5);
      check("over_freeze", int'(ball_freeze), 1);

      // New game out of OVER
      new_game = 1'b1; tick(1); new_game = 1'b0;
      check("ng_score1", int'(score_1), 0);
      check("ng_score2", int'(score_2), 0);
      check("ng_freeze", int'(ball_freeze), 0);
      miss_right = 1'b1; tick(1); miss_right = 1'b0;
      check("ng_goal1", int'(goal_player_1), 1);
      tick(100);

      // Simultaneous events
      miss_left = 1'b1; miss_right = 1'b1; tick(1);
      check("both_score1", int'(score_1), 1);
      check("both_score2", int'(score_2), 0);
      check("both_goal1",  int'(goal_player_1), 0);
      check("both_freeze", int'(ball_freeze), 0);
      miss_left = 1'b0; new_game = 1'b1; tick(1);
      miss_right = 1'b0; new_game = 1'b0;
      check("ngmiss_score1", int'(score_1), 0);
      check("ngmiss_goal1",  int'(goal_player_1), 0);
      check("ngmiss_freeze", int'(ball_freeze), 0);

      // Held miss input
      hits = 0; first_hit = 0; second_hit = 0;
      miss_right = 1'b1;
      for (int c = 1; c <= 150; c++) begin
         tick(1);
         if (goal_player_1) begin
            hits++;
            if (hits == 1) first_hit = c;
            if (hits == 2) second_hit = c;
         end
      end
      miss_right = 1'b0;
      check("held_hits", hits, 2);
      check("held_first", first_hit, 1);
      check("held_second", second_hit, 102);
      check("held_score1", int'(score_1), 2);
      tick(60);

      // Reset in the middle of a hold
      miss_right = 1'b1; tick(1); miss_right = 1'b0;
      tick(40);
      #2 rst = 1'b1;
      #1;
      check("midrst_freeze", int'(ball_freeze), 0);
      check("midrst_score1", int'(score_1), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      miss_right = 1'b1; tick(1); miss_right = 1'b0;
      check("postrst_score1", int'(score_1), 1);
      check("postrst_goal1",  int'(goal_player_1), 1);
      tick(101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
